mem_lsu: RTL and testbench

- Parametrised successor to the current combinational MEM stage; sits between the ex_mem and mem_wb registers.
- Non-memory instructions pass straight through with their ALU result.
- Loads and stores run a request/grant/response bus transaction, with byte/half/word formatting and sign extension.
- Produces misalignment and access-fault exceptions, a bus timeout, and a pipeline stall.
- All results to mem_wb are registered, so the block adds one cycle of latency.

---
 rtl/mem_lsu_pkg.sv | 18 +
 rtl/mem_lsu_align.sv | 28 ++
 rtl/mem_lsu.sv | 110 +++++++++++
 tb/tb_mem_lsu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: opcodes, funct3 codes, exception causes and FSM states shared by the LSU files.
package mem_lsu_pkg;
  localparam logic [6:0] INST_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [2:0] INST_LB = 3'b000;
  localparam logic [2:0] INST_LH = 3'b001;
  localparam logic [2:0] INST_LW = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB = 3'b000;
  localparam logic [2:0] INST_SH = 3'b001;
  localparam logic [2:0] INST_SW = 3'b010;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT = 4'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: byte-enable, store lane replication, load extraction/extension and misalignment check.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misalign
);
  logic is_byte, is_half, sext;
  logic [7:0] lb;
  logic [15:0] lh;
  always_comb begin
    is_byte = funct3[1:0] == INST_SB[1:0];
    is_half = funct3[1:0] == INST_SH[1:0];
    sext = funct3 == INST_LB || funct3 == INST_LH;
    lb = rdata[{addr, 3'b000} +: 8];
    lh = addr[1] ? rdata[31:16] : rdata[15:0];
    misalign = (is_half & addr[0]) | (!is_byte && !is_half && addr != 2'b00);
    be = is_byte ? 4'b0001 << addr : is_half ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = is_byte ? {4{rs2[7:0]}} : is_half ? {2{rs2[15:0]}} : rs2;
    ldata = is_byte ? {{24{sext & lb[7]}}, lb} : is_half ? {{16{sext & lh[15]}}, lh} : rdata;
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: registered MEM stage running a req/gnt/rvalid bus for loads and stores, with
// misalignment, access-fault and timeout exceptions and a combinational pipeline stall.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int TMO_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       instaddr_i,
  input  logic              regs_wen_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [31:0]       rd_data_i,
  input  logic [31:0]       rs2_data_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_err_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       instaddr_o,
  output logic              regs_wen_o,
  output logic [4:0]        rd_addr_o,
  output logic [31:0]       rd_data_o,
  output logic              exc_valid_o,
  output logic [3:0]        exc_cause_o,
  output logic [31:0]       exc_tval_o
);
  state_t state, state_nx;
  logic [TMO_W-1:0] cnt;
  logic is_load, is_store, mem_op, misalign, tmo, done, tmo_fault, load_en, exc_nx, wen_nx;
  logic [3:0] cause_nx;
  logic [31:0] ldata, data_nx;

  mem_lsu_align u_align (
    .funct3   (inst_i[14:12]),
    .addr     (rd_data_i[1:0]),
    .rs2      (rs2_data_i),
    .rdata    (mem_rdata_i),
    .be       (mem_be_o),
    .wdata    (mem_wdata_o),
    .ldata    (ldata),
    .misalign (misalign)
  );

  always_comb begin
    is_load = valid_i && inst_i[6:0] == INST_TYPE_LOAD;
    is_store = valid_i && inst_i[6:0] == INST_TYPE_S;
    mem_op = is_load | is_store;
    tmo = TIMEOUT_CYC != 0 && state != IDLE && cnt == TMO_W'(TIMEOUT_CYC);
    done = state == WAIT && mem_rvalid_i;
    tmo_fault = tmo & !done;
    stall_o = (state == IDLE && mem_op && !misalign) || (state == REQ && !tmo) ||
              (state == WAIT && !mem_rvalid_i && !tmo);
    mem_req_o = state == REQ;
    mem_we_o = is_store;
    mem_addr_o = {rd_data_i[ADDR_W-1:2], 2'b00};
    state_nx = state == IDLE ? (mem_op && !misalign ? REQ : IDLE) :
               (done || tmo) ? IDLE :
               (state == REQ && mem_gnt_i) ? WAIT : state;
    load_en = (state == IDLE && valid_i && (!mem_op || misalign)) || done || tmo_fault;
    // In IDLE the only exception source is misalignment; otherwise it is a bus error or timeout.
    exc_nx = state == IDLE ? mem_op & misalign : (done & mem_err_i) | tmo_fault;
    cause_nx = !exc_nx ? 4'd0 :
               state == IDLE ? (is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN) :
               (is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT);
    wen_nx = regs_wen_i & !exc_nx & !is_store;
    data_nx = is_load && !exc_nx ? ldata : rd_data_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      valid_o <= 1'b0;
      inst_o <= '0;
      instaddr_o <= '0;
      regs_wen_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      exc_valid_o <= 1'b0;
      exc_cause_o <= '0;
      exc_tval_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      valid_o <= load_en;
      if (load_en) begin
        inst_o <= inst_i;
        instaddr_o <= instaddr_i;
        regs_wen_o <= wen_nx;
        rd_addr_o <= rd_addr_i;
        rd_data_o <= data_nx;
        exc_valid_o <= exc_nx;
        exc_cause_o <= cause_nx;
        exc_tval_o <= exc_nx ? rd_data_i : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench with directed and random load/store/ALU traffic against a behavioural model.
module tb_mem_lsu;
  localparam int TMO = 8;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic clk, rstn, valid_i, regs_wen_i, stall_o, mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic valid_o, regs_wen_o, exc_valid_o;
  logic [31:0] inst_i, instaddr_i, rd_data_i, rs2_data_i, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] inst_o, instaddr_o, rd_data_o, exc_tval_o;
  logic [4:0] rd_addr_i, rd_addr_o;
  logic [3:0] mem_be_o, exc_cause_o;

  typedef struct {
    logic [31:0] inst, pc, data, tval;
    logic        wen, chk_data, exc;
    logic [4:0]  rd;
    logic [3:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int n_chk = 0, n_fail = 0, nreq = 0;

  mem_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TMO), .TMO_W(8)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .inst_i(inst_i), .instaddr_i(instaddr_i),
    .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .valid_o(valid_o), .inst_o(inst_o),
    .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int sz;
    longint v;
    sz = 1 << f3[1:0];
    v = longint'(w >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    if (!f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v -= (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
    int sz;
    sz = 1 << f3[1:0];
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    return f3[1:0] == 2'd0 ? rs2[7:0] * 32'h0101_0101 : f3[1:0] == 2'd1 ? rs2[15:0] * 32'h0001_0001 : rs2;
  endfunction

  always @(negedge clk) begin
    if (rstn && valid_o) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: valid_o=1 inst_o=%h, required no output", inst_o);
      end else begin
        m = exp_q.pop_front();
        chk("out_inst", inst_o, m.inst);
        chk("out_pc", instaddr_o, m.pc);
        chk("out_wen", 32'(regs_wen_o), 32'(m.wen));
        chk("out_rd", 32'(rd_addr_o), 32'(m.rd));
        chk("out_exc", 32'(exc_valid_o), 32'(m.exc));
        if (m.exc) begin
          chk("out_cause", 32'(exc_cause_o), 32'(m.cause));
          chk("out_tval", exc_tval_o, m.tval);
        end
        if (m.chk_data) chk("out_data", rd_data_o, m.data);
      end
    end
  end

  task automatic step(output logic st);
    @(negedge clk);
    st = stall_o;
    if (mem_req_o) nreq++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic st;
    valid_i = 1'b0;
    repeat (n) step(st);
  endtask

  task automatic run(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] rs2, input logic [31:0] rdata, input int gd, input int rd,
                     input logic err, input logic hang);
    logic [31:0] inst, pc;
    logic [4:0] rda;
    logic wen, ld, sr, mem, mis, st;
    int nst, sz, k;
    exp_t e;
    inst = $urandom;
    inst[6:0] = opc;
    inst[14:12] = f3;
    pc = $urandom & ~32'd3;
    wen = ($urandom % 4) != 0;
    rda = 5'($urandom);
    ld = opc == OP_LD;
    sr = opc == OP_ST;
    mem = ld | sr;
    sz = 1 << f3[1:0];
    mis = mem && ((addr % sz) != 0);
    e.inst = inst; e.pc = pc; e.rd = rda; e.data = addr; e.tval = addr;
    e.wen = wen; e.chk_data = 1'b1; e.exc = 1'b0; e.cause = 4'd0;
    if (mem) begin
      e.exc = mis | err | hang;
      e.cause = mis ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
      e.wen = ld & wen & !e.exc;
      e.chk_data = ld & !e.exc;
      e.data = load_val(f3, addr[1:0], rdata);
    end
    valid_i = 1'b1; inst_i = inst; instaddr_i = pc; regs_wen_i = wen; rd_addr_i = rda;
    rd_data_i = addr; rs2_data_i = rs2;
    exp_q.push_back(e);
    nreq = 0;
    nst = 0;
    if (!mem || mis) begin
      step(st);
      chk("stall_nomem", 32'(st), 32'd0);
      chk("req_nomem", 32'(nreq), 32'd0);
    end else begin
      step(st); nst += int'(st);
      repeat (gd) begin step(st); nst += int'(st); end
      chk("bus_req", 32'(mem_req_o), 32'd1);
      chk("bus_we", 32'(mem_we_o), 32'(sr));
      chk("bus_addr", mem_addr_o, addr & ~32'd3);
      chk("bus_be", 32'(mem_be_o), 32'(exp_be(f3, addr[1:0])));
      if (sr) chk("bus_wdata", mem_wdata_o, exp_wdata(f3, rs2));
      mem_gnt_i = 1'b1;
      step(st); nst += int'(st);
      mem_gnt_i = 1'b0;
      if (hang) begin
        k = 0;
        st = 1'b1;
        while (st && k < TMO + 4) begin step(st); nst += int'(st); k++; end
        chk("tmo_stall_drop", 32'(st), 32'd0);
        chk("tmo_stall_cycles", 32'(nst), 32'(1 + TMO));
      end else begin
        repeat (rd) begin step(st); nst += int'(st); end
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
        step(st);
        chk("stall_done", 32'(st), 32'd0);
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = $urandom;
        chk("stall_cycles", 32'(nst), 32'(2 + gd + rd));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic st;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] a;
    int kind, sz;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0] alu_op [3] = '{7'b0010011, 7'b0110011, 7'b0110111};
    rstn = 1'b0; valid_i = 1'b0; inst_i = '0; instaddr_i = '0; regs_wen_i = 1'b0; rd_addr_i = '0;
    rd_data_i = '0; rs2_data_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_wen", 32'(regs_wen_o), 32'd0);
    chk("rst_exc", 32'(exc_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_data", rd_data_o, 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rstn = 1'b1;
    idle(1);

    run(OP_ALU, 3'd0, 32'h1234, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    run(OP_LD, 3'b000, 32'h103, 32'd0, 32'h80FF_FF00, 2, 0, 1'b0, 1'b0);
    run(OP_LD, 3'b101, 32'h102, 32'd0, 32'hBEEF_0000, 0, 1, 1'b0, 1'b0);
    run(OP_ST, 3'b000, 32'h101, 32'hAB, 32'h0, 1, 0, 1'b0, 1'b0);
    run(OP_LD, 3'b010, 32'h102, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    run(OP_ST, 3'b001, 32'h001, 32'h1234_5678, 32'd0, 0, 0, 1'b0, 1'b0);
    run(OP_LD, 3'b010, 32'h200, 32'd0, 32'd0, 1, 0, 1'b0, 1'b1);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    run(OP_ALU, 3'd0, 32'h0000_0042, 32'd0, 32'd0, 0, 0, 1'b0, 1'b0);
    mem_rvalid_i = 1'b0;
    run(OP_LD, 3'b010, 32'h204, 32'd0, 32'hCAFE_F00D, 0, 2, 1'b0, 1'b0);
    run(OP_LD, 3'b001, 32'h206, 32'd0, 32'h8001_0000, 0, 0, 1'b1, 1'b0);
    run(OP_ST, 3'b010, 32'h208, 32'h0BAD_CAFE, 32'd0, 1, 1, 1'b1, 1'b0);
    run(OP_ST, 3'b001, 32'h20A, 32'hFFFF_9876, 32'd0, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      opc = kind == 0 ? alu_op[$urandom_range(0, 2)] : kind == 1 ? OP_LD : OP_ST;
      f3 = kind == 1 ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom;
      sz = 1 << f3[1:0];
      if ($urandom % 3 != 0) a = a & ~32'(sz - 1);
      run(opc, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
          ($urandom % 8) == 0, 1'b0);
      if ($urandom % 4 == 0) idle($urandom_range(1, 2));
    end

    valid_i = 1'b1; inst_i = {17'h0, 3'b010, 5'd3, OP_LD}; instaddr_i = 32'h80; regs_wen_i = 1'b1;
    rd_addr_i = 5'd3; rd_data_i = 32'h300;
    step(st);
    mem_gnt_i = 1'b1;
    step(st);
    mem_gnt_i = 1'b0;
    rstn = 1'b0; valid_i = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_inst", inst_o, 32'd0);
    chk("arst_pc", instaddr_o, 32'd0);
    chk("arst_data", rd_data_o, 32'd0);
    chk("arst_exc", 32'(exc_valid_o), 32'd0);
    chk("arst_req", 32'(mem_req_o), 32'd0);
    chk("arst_stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run(OP_LD, 3'b010, 32'h400, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
